// File: rtl/cd_period_meter_pkg.sv
// Shared widths and FSM encoding for the clock-divider period meter.
package cd_period_meter_pkg;

  localparam int unsigned CLK_MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/cd_sync_edge.sv
// Two-flop synchronizer for an asynchronous clock, plus a delay flop giving a both-edge strobe.
module cd_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic clkin,
  output logic edge_det
);

  logic sync1;
  logic sync2;
  logic dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= clkin;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign edge_det = sync2 ^ dly;

endmodule

// File: rtl/cd_period_meter.sv
// Measures the half-period of clkin in clk cycles, reporting the divider limit that would regenerate it.
module cd_period_meter
  import cd_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH      = CLK_MAX_WIDTH,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOL        = 1,
  parameter int unsigned TIMEOUT    = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clkin,
  output logic [WIDTH-1:0] limit_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned     MW     = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TO_V  = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] TOL_V = WIDTH'(TOL);
  localparam logic [MW-1:0]    LCK_V = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]    M_ONE = MW'(1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [MW-1:0]    match_cnt;
  logic             have_prev;
  logic             edge_det;

  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] diff;
  logic             is_match;
  logic [MW-1:0]    match_nxt;

  cd_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .clkin    (clkin),
    .edge_det (edge_det)
  );

  // limit_out doubles as the previous measurement; have_prev marks it as valid since IDLE.
  always_comb begin
    cnt_inc   = (cnt == '1) ? cnt : cnt + ONE;
    diff      = (cnt >= limit_out) ? (cnt - limit_out) : (limit_out - cnt);
    is_match  = have_prev && (diff <= TOL_V);
    match_nxt = (match_cnt == LCK_V) ? match_cnt : match_cnt + M_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      match_cnt  <= '0;
      have_prev  <= 1'b0;
      limit_out  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else if (!en) begin
      state      <= IDLE;
      cnt        <= '0;
      match_cnt  <= '0;
      have_prev  <= 1'b0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      cnt        <= edge_det ? ONE : cnt_inc;
      case (state)
        IDLE: begin
          if (edge_det) begin
            state     <= MEASURE;
            timeout   <= 1'b0;
            match_cnt <= '0;
            have_prev <= 1'b0;
          end
        end
        MEASURE, LOCKED: begin
          if (edge_det) begin
            limit_out  <= cnt;
            meas_valid <= 1'b1;
            have_prev  <= 1'b1;
            timeout    <= 1'b0;
            if (is_match) begin
              match_cnt <= match_nxt;
              if (match_nxt == LCK_V) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
              locked    <= 1'b0;
              state     <= MEASURE;
            end
          end else if (cnt == TO_V) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
            have_prev <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cd_period_meter.sv
// Directed bench for cd_period_meter: clkin toggled at hand-chosen spacings, outputs checked 3 cycles after each toggle.
module tb_cd_period_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clkin;
  logic [7:0] limit_out;
  logic       meas_valid;
  logic       locked;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  cd_period_meter #(
    .WIDTH      (8),
    .LOCK_COUNT (4),
    .TOL        (1),
    .TIMEOUT    (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clkin      (clkin),
    .limit_out  (limit_out),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int v, input int lim, input int lk, input int to);
    chk({tag, ".meas_valid"}, 32'(meas_valid), v);
    chk({tag, ".limit_out"},  32'(limit_out),  lim);
    chk({tag, ".locked"},     32'(locked),     lk);
    chk({tag, ".timeout"},    32'(timeout),    to);
  endtask

  // Toggle clkin, check the result of that edge, then idle so the next toggle is 'gap' cycles later.
  task automatic do_edge(input int gap, input int v, input int lim, input int lk, input int to,
                         input string tag);
    clkin = ~clkin;
    tick(3);
    chk_all(tag, v, lim, lk, to);
    if (gap > 3) tick(gap - 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    clkin = 1'b0;
    tick(2);
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    en  = 1'b1;
    tick(2);

    // Half-period 5: no measurement on the first edge, lock with the 6th.
    do_edge(5, 0, 0, 0, 0, "l5.e1");
    do_edge(5, 1, 5, 0, 0, "l5.e2");
    do_edge(5, 1, 5, 0, 0, "l5.e3");
    do_edge(5, 1, 5, 0, 0, "l5.e4");
    do_edge(5, 1, 5, 0, 0, "l5.e5");
    do_edge(9, 1, 5, 1, 0, "l5.e6");

    // Retune to 9: first 9 unlocks, four further matches relock.
    do_edge(9, 1, 9, 0, 0, "l9.e7");
    do_edge(9, 1, 9, 0, 0, "l9.e8");
    do_edge(9, 1, 9, 0, 0, "l9.e9");
    do_edge(9, 1, 9, 0, 0, "l9.e10");
    do_edge(10, 1, 9, 1, 0, "l9.e11");

    // Tolerance edge: 9->10 holds lock, 10->8 breaks it.
    do_edge(8, 1, 10, 1, 0, "tol.in");
    do_edge(8, 1, 8, 0, 0, "tol.out");
    do_edge(8, 1, 8, 0, 0, "l8.e14");
    do_edge(8, 1, 8, 0, 0, "l8.e15");
    do_edge(8, 1, 8, 0, 0, "l8.e16");
    do_edge(3, 1, 8, 1, 0, "l8.e17");

    // clkin stuck: timeout fires when cnt has reached 20.
    tick(19);
    chk_all("to.before", 0, 8, 1, 0);
    tick(1);
    chk_all("to.fire", 0, 8, 0, 1);
    tick(2);
    chk_all("to.hold", 0, 8, 0, 1);

    // Next edge clears timeout without measuring; the following edge lands on cnt==TIMEOUT.
    do_edge(20, 0, 8, 0, 0, "to.clear");
    do_edge(6, 1, 20, 0, 0, "to.edge_wins");

    // Lock at 6, then reset mid-lock.
    do_edge(6, 1, 6, 0, 0, "l6.e1");
    do_edge(6, 1, 6, 0, 0, "l6.e2");
    do_edge(6, 1, 6, 0, 0, "l6.e3");
    do_edge(6, 1, 6, 0, 0, "l6.e4");
    do_edge(3, 1, 6, 1, 0, "l6.e5");
    tick(1);
    rst   = 1'b1;
    clkin = 1'b0;
    tick(1);
    rst = 1'b0;
    chk_all("midrst", 0, 0, 0, 0);
    tick(2);

    // Relock at 5, then disable for 3 cycles with an edge arriving in the first disabled cycle.
    do_edge(5, 0, 0, 0, 0, "en.e1");
    for (int i = 0; i < 4; i++) do_edge(5, 1, 5, 0, 0, $sformatf("en.e%0d", i + 2));
    do_edge(3, 1, 5, 1, 0, "en.e6");
    clkin = ~clkin;
    tick(2);
    en = 1'b0;
    tick(1);
    chk_all("en.off", 0, 5, 0, 0);
    tick(2);
    en = 1'b1;
    tick(5);
    do_edge(5, 0, 5, 0, 0, "en.first");
    do_edge(3, 1, 5, 0, 0, "en.second");

    // Half-period 1: clkin toggles every clk cycle.
    rst   = 1'b1;
    clkin = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      clkin = ~clkin;
      tick(1);
    end
    tick(1);
    chk_all("l1.e5", 1, 1, 0, 0);
    tick(1);
    chk_all("l1.e6", 1, 1, 1, 0);
    tick(1);
    chk_all("l1.after", 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
